aes_sbox: RTL and testbench
===========================

AES_SBOX -- requirements
Module: aes_sbox

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 8 bits.
REQ-002 clk  input  1  single clock; all registered state changes on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-004 in  input  8  byte to substitute, MSB = bit 7.
REQ-005 out  output  8  combinational substitution S(in), zero latency.
REQ-006 out_q  output  8  registered copy of S(in), one-cycle latency.

Function
REQ-007 out SHALL equal the FIPS-197 forward S-box value of in for all 256 inputs, purely combinationally.
- No clock or reset dependency on out.
- Key expansion reads out in the same half-cycle it drives in.
REQ-008 S(x) SHALL be defined as follows:
- Multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1, with 0x00 mapped to 0x00.
- Followed by the affine transform b'i = bi ^ b(i+4) ^ b(i+5) ^ b(i+6) ^ b(i+7) ^ ci, with c = 0x63 and indices mod 8.
REQ-009 The mapping SHALL be a bijection; no two inputs give the same output.
REQ-010 Table boundary values:
- S(0x00)=0x63 and S(0xFF)=0x16.
- The block SHALL have no fixed points or opposite fixed points.
REQ-011 out SHALL settle to a defined 8-bit value for any defined in, with no latches.
REQ-012 If in contains X/Z bits, out is don't-care (X permitted).
REQ-013 On each rising clk edge with rst=1, out_q SHALL load S(in) as sampled at that edge.
REQ-014 out_q SHALL hold its value between edges.
REQ-015 There is no enable or handshake; the block accepts a new input every cycle, including back-to-back changes.
REQ-016 If in changes on the same edge as reset release, the first non-reset edge loads S(in) sampled at that edge.

Reset
REQ-017 While rst=0 at a rising clk edge, out_q SHALL become 0x00.
REQ-018 Reset SHALL NOT affect out, which keeps tracking S(in) during reset.
REQ-019 Reset asserted mid-stream SHALL override the load on that edge.
REQ-020 No initial blocks SHALL be relied upon for functional reset.

Structure
REQ-021 The 256-entry forward S-box table SHALL live as a constant array in shared package aes_pkg.
- The package is also used by key expansion and SubBytes.
- A 256-entry inverse S-box constant SHALL sit beside it for decryption.
REQ-022 aes_sbox SHALL implement the lookup as a case statement or indexed constant read, with no sub-modules.
- A GF-inverse-plus-affine implementation is also acceptable if it is bit-exact to the table.
REQ-023 Key expansion SHALL instantiate four aes_sbox copies for one 32-bit SubWord.

Verification
REQ-024 Exhaustive sweep: drive in=0x00..0xFF.
- Each out SHALL match the golden table, e.g. 0x00->0x63, 0x01->0x7C, 0x53->0xED, 0x10->0xCA, 0x63->0xFB, 0xFF->0x16.
- All 256 outputs SHALL be distinct.
REQ-025 Registered path: with rst=1, drive in=0x53 before an edge.
- out SHALL read 0xED immediately.
- out_q SHALL read 0xED only after that edge.
REQ-026 Reset: hold rst=0 for 2 edges with in=0x01.
- out_q SHALL be 0x00 while out stays 0x7C.
- After release, the first edge SHALL give out_q=0x7C.
REQ-027 Back-to-back: change in every cycle through 0x00, 0xFF, 0x53.
- out_q SHALL follow 0x63, 0x16, 0xED on consecutive edges.
REQ-028 SubWord check: four instances fed rotated word cf 4f 3c 09 (from AES-128 key 2b7e1516 28aed2a6 abf71588 09cf4f3c) SHALL output 8a 84 eb 01.
REQ-029 Key expansion integration: the expanded schedule word w4 SHALL equal a0fafe17.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants: forward S-box table and its inverse
// Used by aes_sbox, SubBytes and key expansion.
package aes_pkg;

    typedef logic [7:0] sbox_t [256];

    localparam sbox_t SBOX = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // The inverse table is derived from the forward one at elaboration so the two can never disagree.
    function automatic sbox_t invert_table(input sbox_t fwd);
        sbox_t r;
        for (int i = 0; i < 256; i++) begin
            r[fwd[i]] = 8'(i);
        end
        return r;
    endfunction

    localparam sbox_t INV_SBOX = invert_table(SBOX);

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox_if.sv
// rtl/aes_sbox_if.sv - byte substitution bus: input byte, combinational and registered results
interface aes_sbox_if;
    logic [7:0] in;
    logic [7:0] out;
    logic [7:0] out_q;

    modport master (output in, input out, input out_q);
    modport slave  (input in, output out, output out_q);
endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - forward AES S-box: zero-latency lookup plus a registered copy
// out never sees clk or rst so key expansion can use it within the same half-cycle.
module aes_sbox
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    aes_sbox_if.slave   bus
);

    assign bus.out = SBOX[bus.in];

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.out_q <= 8'h00;
        end else begin
            bus.out_q <= SBOX[bus.in];
        end
    end

endmodule

// File: tb/tb_aes_sbox.sv
// tb/tb_aes_sbox.sv - scoreboard bench for aes_sbox against a GF(2^8) reference model
module tb_aes_sbox;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    aes_sbox_if bus ();
    aes_sbox_if sw0 ();
    aes_sbox_if sw1 ();
    aes_sbox_if sw2 ();
    aes_sbox_if sw3 ();

    aes_sbox dut  (.clk(clk), .rst(rst), .bus(bus));
    aes_sbox sb0  (.clk(clk), .rst(rst), .bus(sw0));
    aes_sbox sb1  (.clk(clk), .rst(rst), .bus(sw1));
    aes_sbox sb2  (.clk(clk), .rst(rst), .bus(sw2));
    aes_sbox sb3  (.clk(clk), .rst(rst), .bus(sw3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ref_s [256];
    logic [7:0] q_exp [$];
    logic [7:0] c_exp [$];
    logic [7:0] last_q_exp;
    bit         have_last = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] model_s(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive at the falling edge; the registered expectation is for the next rising edge.
    task automatic apply(input logic r, input logic [7:0] v);
        @(negedge clk);
        rst    = r;
        bus.in = v;
        #1;
        check("out_comb", {24'h0, bus.out}, {24'h0, ref_s[v]});
        if (have_last) check("out_q_hold", {24'h0, bus.out_q}, {24'h0, last_q_exp});
        q_exp.push_back(r ? ref_s[v] : 8'h00);
        c_exp.push_back(ref_s[v]);
    endtask

    always @(posedge clk) begin
        #1;
        if (q_exp.size() > 0) begin
            logic [7:0] eq, ec;
            eq = q_exp.pop_front();
            ec = c_exp.pop_front();
            check("out_q_edge", {24'h0, bus.out_q}, {24'h0, eq});
            check("out_at_edge", {24'h0, bus.out}, {24'h0, ec});
            last_q_exp = eq;
            have_last  = 1'b1;
        end
    end

    logic [7:0] golden_in  [6] = '{8'h00, 8'h01, 8'h53, 8'h10, 8'h63, 8'hff};
    logic [7:0] golden_out [6] = '{8'h63, 8'h7c, 8'hed, 8'hca, 8'hfb, 8'h16};

    initial begin
        bit   seen [256];
        int   dups, fixed;
        logic [31:0] subword, w4;

        rst    = 1'b0;
        bus.in = 8'h00;
        sw0.in = 8'h00; sw1.in = 8'h00; sw2.in = 8'h00; sw3.in = 8'h00;
        for (int i = 0; i < 256; i++) ref_s[i] = model_s(8'(i));

        // Reset held for two edges, then released with the same input.
        apply(1'b0, 8'h01);
        apply(1'b0, 8'h01);
        apply(1'b1, 8'h01);

        // Registered path, then back-to-back changes.
        apply(1'b1, 8'h53);
        apply(1'b1, 8'h00);
        apply(1'b1, 8'hff);
        apply(1'b1, 8'h53);

        // Exhaustive sweep on the combinational output.
        dups = 0; fixed = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            apply(1'b1, 8'(i));
            if (seen[bus.out]) dups++;
            seen[bus.out] = 1'b1;
            if (bus.out == 8'(i) || bus.out == ~8'(i)) fixed++;
            for (int g = 0; g < 6; g++) begin
                if (golden_in[g] == 8'(i)) check("golden", {24'h0, bus.out}, {24'h0, golden_out[g]});
            end
        end
        check("distinct_dups", dups, 0);
        check("fixed_points", fixed, 0);

        // Reset asserted mid-stream overrides the load; random traffic with occasional resets.
        apply(1'b0, 8'h77);
        apply(1'b1, 8'h77);
        for (int i = 0; i < 200; i++) begin
            apply(($urandom_range(0, 9) != 0), 8'($urandom));
        end

        // SubWord of RotWord(w3) for the AES-128 test key, then w4.
        sw0.in = 8'hcf; sw1.in = 8'h4f; sw2.in = 8'h3c; sw3.in = 8'h09;
        #1;
        subword = {sw0.out, sw1.out, sw2.out, sw3.out};
        check("subword_ref", subword, {ref_s[8'hcf], ref_s[8'h4f], ref_s[8'h3c], ref_s[8'h09]});
        check("subword", subword, 32'h8a84eb01);
        w4 = 32'h2b7e1516 ^ subword ^ 32'h01000000;
        check("w4", w4, 32'ha0fafe17);

        for (int n = 0; n < 5 && q_exp.size() > 0; n++) @(posedge clk);
        #2;
        check("scoreboard_drained", q_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
